// File: rtl/vga_pkg.sv
// Shared constants and write-sequencer state encoding for the PPU-to-VGA scanline path.
package vga_pkg;

  localparam int LINE_W_DEF        = 160;
  localparam int ADDR_W_DEF        = 8;
  localparam int VISIBLE_LINES_DEF = 144;
  localparam int FIFO_DEPTH_DEF    = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RELEASE = 2'd3
  } wr_state_t;

endpackage

// File: rtl/line_fifo.sv
// Small synchronous FIFO holding pending scanlines.
// A push is accepted while full when a pop happens on the same edge.
module line_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_FULL);
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_reg[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
          mem_reg[gi] <= din;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      if (do_push && !do_pop)      count_reg <= count_reg + CNT_ONE;
      else if (do_pop && !do_push) count_reg <= count_reg - CNT_ONE;
    end
  end

endmodule

// File: rtl/ppu_line_write_ctrl.sv
// Queues finished PPU scanlines and writes them into the VGA scanline RAMs in setup/strobe/release steps.
// Optional LINE_DROP_CNT_EN adds a saturating drop_count output.
module ppu_line_write_ctrl
  import vga_pkg::*;
#(
  parameter int LINE_W        = LINE_W_DEF,
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int VISIBLE_LINES = VISIBLE_LINES_DEF,
  parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF
) (
  input  logic              pixelClk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] LY,
  input  logic              updateBufferSignal,
  input  logic [LINE_W-1:0] LineBuffer0,
  input  logic [LINE_W-1:0] LineBuffer1,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LINE_W-1:0] wr_data0,
  output logic [LINE_W-1:0] wr_data1,
  output logic              wr_en,
  output logic              busy,
  output logic              overflow,
`ifdef LINE_DROP_CNT_EN
  output logic [7:0]        drop_count,
`endif
  output logic              frame_start
);

  localparam int ENTRY_W = ADDR_W + 2 * LINE_W;
  localparam logic [ADDR_W:0] VIS_LIMIT = (ADDR_W + 1)'(VISIBLE_LINES);

  wr_state_t          state_reg;
  logic [ADDR_W-1:0]  last_ly_reg;
  logic               event_hit;
  logic               capture_req;
  logic               line_drop;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_din;
  logic [ENTRY_W-1:0] fifo_head;

  assign event_hit   = updateBufferSignal && (LY != last_ly_reg);
  assign capture_req = event_hit && ({1'b0, LY} < VIS_LIMIT);
  assign fifo_pop    = (state_reg == RELEASE);
  // A full FIFO still accepts the line if the sequencer frees a slot this edge.
  assign line_drop   = capture_req && fifo_full && !fifo_pop;
  assign fifo_push   = capture_req && !line_drop;
  assign fifo_din    = {LY, LineBuffer1, LineBuffer0};
  assign busy        = (state_reg != IDLE) || !fifo_empty;

  line_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_line_fifo (
    .clk   (pixelClk),
    .srst  (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge pixelClk) begin
    if (reset) begin
      state_reg   <= IDLE;
      last_ly_reg <= '1;
      wr_addr     <= '0;
      wr_data0    <= '0;
      wr_data1    <= '0;
      wr_en       <= 1'b0;
      overflow    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (event_hit) last_ly_reg <= LY;
      frame_start <= capture_req && (LY == '0);
      if (line_drop) overflow <= 1'b1;
      case (state_reg)
        IDLE: begin
          wr_en <= 1'b0;
          if (!fifo_empty) begin
            wr_addr   <= fifo_head[ENTRY_W-1 -: ADDR_W];
            wr_data1  <= fifo_head[2*LINE_W-1 -: LINE_W];
            wr_data0  <= fifo_head[LINE_W-1:0];
            state_reg <= SETUP;
          end
        end
        SETUP: begin
          wr_en     <= 1'b1;
          state_reg <= STROBE;
        end
        STROBE: begin
          wr_en     <= 1'b0;
          state_reg <= RELEASE;
        end
        RELEASE: begin
          wr_en     <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          wr_en     <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifdef LINE_DROP_CNT_EN
  always_ff @(posedge pixelClk) begin
    if (reset) begin
      drop_count <= '0;
    end else if (line_drop && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ppu_line_write_ctrl.sv
// Directed bench for ppu_line_write_ctrl; drop counter checks run when LINE_DROP_CNT_EN is defined.
module tb_ppu_line_write_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   ly;
  logic         upd;
  logic [159:0] lb0;
  logic [159:0] lb1;
  logic [7:0]   wr_addr;
  logic [159:0] wr_data0;
  logic [159:0] wr_data1;
  logic         wr_en;
  logic         busy;
  logic         overflow;
  logic         frame_start;
`ifdef LINE_DROP_CNT_EN
  logic [7:0]   drop_count;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [7:0]   log_addr [$];
  int           log_cyc  [$];
  logic [159:0] log_d0   [$];
  logic [159:0] log_d1   [$];

  always #5 clk = ~clk;

  ppu_line_write_ctrl dut (
    .pixelClk           (clk),
    .reset              (reset),
    .LY                 (ly),
    .updateBufferSignal (upd),
    .LineBuffer0        (lb0),
    .LineBuffer1        (lb1),
    .wr_addr            (wr_addr),
    .wr_data0           (wr_data0),
    .wr_data1           (wr_data1),
    .wr_en              (wr_en),
    .busy               (busy),
    .overflow           (overflow),
`ifdef LINE_DROP_CNT_EN
    .drop_count         (drop_count),
`endif
    .frame_start        (frame_start)
  );

  function automatic logic [159:0] plane(input logic [7:0] l, input logic sel);
    logic [7:0] tag;
    tag = sel ? 8'h3C : 8'hC3;
    return {5{{tag, 8'h96, 8'h11, l}}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (wr_en === 1'b1) begin
      log_addr.push_back(wr_addr);
      log_cyc.push_back(cyc);
      log_d0.push_back(wr_data0);
      log_d1.push_back(wr_data1);
      $display("write: cyc=%0d addr=%0d", cyc, wr_addr);
    end
  endtask

  task automatic set_line(input logic [7:0] l);
    ly  = l;
    lb0 = plane(l, 1'b0);
    lb1 = plane(l, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    upd   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    log_addr.delete();
    log_cyc.delete();
    log_d0.delete();
    log_d1.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    upd   = 1'b0;
    set_line(8'd0);
    tick();
    tick();
    total++;
    if ({wr_en, busy, overflow, frame_start} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: got %b want 0000", {wr_en, busy, overflow, frame_start});
    end
    total++;
    if ({wr_addr, wr_data0, wr_data1} !== '0) begin
      bad++;
      $display("FAIL reset_data: got addr=%h want 0 with zero data", wr_addr);
    end
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single_line();
    int c0;
    do_reset();
    set_line(8'd5);
    upd = 1'b1;
    tick();
    c0  = cyc;
    upd = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
    for (int i = 0; i < 8; i++) tick();
    total++;
    if (log_addr.size() != 1) begin
      bad++;
      $display("FAIL single_count: got %0d want 1", log_addr.size());
    end else begin
      total++;
      if (log_addr[0] !== 8'd5) begin bad++; $display("FAIL single_addr: got %0d want 5", log_addr[0]); end
      total++;
      if (log_cyc[0] != c0 + 2) begin bad++; $display("FAIL single_latency: got %0d want %0d", log_cyc[0] - c0, 2); end
      total++;
      if (log_d0[0] !== plane(8'd5, 1'b0) || log_d1[0] !== plane(8'd5, 1'b1)) begin
        bad++;
        $display("FAIL single_data: got d0=%h want %h", log_d0[0], plane(8'd5, 1'b0));
      end
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL single_idle: busy got %b want 0", busy); end
    $display("test_single_line done");
  endtask

  task automatic test_back_to_back();
    int c0;
    // three lines on consecutive edges: the third finds the FIFO full with no pop
    do_reset();
    upd = 1'b1;
    set_line(8'd10); tick(); c0 = cyc;
    set_line(8'd11); tick();
    set_line(8'd12); tick();
    upd = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    total++;
    if (log_addr.size() != 2) begin
      bad++;
      $display("FAIL b2b_drop_count: got %0d writes want 2", log_addr.size());
    end else begin
      total++;
      if (log_addr[0] !== 8'd10 || log_addr[1] !== 8'd11) begin
        bad++;
        $display("FAIL b2b_drop_addr: got %0d,%0d want 10,11", log_addr[0], log_addr[1]);
      end
      total++;
      if (log_cyc[0] != c0 + 2 || log_cyc[1] != c0 + 6) begin
        bad++;
        $display("FAIL b2b_drop_timing: got %0d,%0d want %0d,%0d", log_cyc[0], log_cyc[1], c0 + 2, c0 + 6);
      end
      total++;
      if (log_d1[1] !== plane(8'd11, 1'b1)) begin bad++; $display("FAIL b2b_drop_data: got %h want %h", log_d1[1], plane(8'd11, 1'b1)); end
    end
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL b2b_overflow: got %b want 1", overflow); end

    // third line arrives on the pop edge: same-edge push and pop while full
    do_reset();
    upd = 1'b1;
    set_line(8'd20); tick(); c0 = cyc;
    set_line(8'd21); tick();
    upd = 1'b0;
    tick();
    tick();
    upd = 1'b1;
    set_line(8'd22); tick();
    upd = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    total++;
    if (log_addr.size() != 3) begin
      bad++;
      $display("FAIL b2b_pop_count: got %0d writes want 3", log_addr.size());
    end else begin
      total++;
      if (log_addr[0] !== 8'd20 || log_addr[1] !== 8'd21 || log_addr[2] !== 8'd22) begin
        bad++;
        $display("FAIL b2b_pop_addr: got %0d,%0d,%0d want 20,21,22", log_addr[0], log_addr[1], log_addr[2]);
      end
      total++;
      if (log_cyc[1] - log_cyc[0] != 4 || log_cyc[2] - log_cyc[1] != 4) begin
        bad++;
        $display("FAIL b2b_pop_spacing: got %0d,%0d want 4,4", log_cyc[1] - log_cyc[0], log_cyc[2] - log_cyc[1]);
      end
    end
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_pop_overflow: got %b want 0", overflow); end
    $display("test_back_to_back done");
  endtask

  task automatic test_vblank_frame();
    int hits;
    hits = 0;
    do_reset();
    upd = 1'b1;
    for (int l = 144; l <= 153; l++) begin
      set_line(8'(l));
      tick();
      if (busy !== 1'b0 || frame_start !== 1'b0) hits++;
    end
    tick();
    total++;
    if (log_addr.size() != 0 || hits != 0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL vblank_quiet: got writes=%0d busy/fs=%0d ovf=%b want 0,0,0", log_addr.size(), hits, overflow);
    end
    set_line(8'd0);
    tick();
    total++;
    if (frame_start !== 1'b1) begin bad++; $display("FAIL frame_start_pulse: got %b want 1", frame_start); end
    upd = 1'b0;
    tick();
    total++;
    if (frame_start !== 1'b0) begin bad++; $display("FAIL frame_start_width: got %b want 0", frame_start); end
    for (int i = 0; i < 6; i++) tick();
    total++;
    if (log_addr.size() != 1 || log_addr[0] !== 8'd0) begin
      bad++;
      $display("FAIL vblank_line0: got %0d writes want 1 at addr 0", log_addr.size());
    end
    $display("test_vblank_frame done");
  endtask

  task automatic test_repeat_ly();
    do_reset();
    upd = 1'b1;
    set_line(8'd7);
    for (int i = 0; i < 20; i++) tick();
    upd = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    total++;
    if (log_addr.size() != 1) begin
      bad++;
      $display("FAIL repeat_count: got %0d writes want 1", log_addr.size());
    end else begin
      total++;
      if (log_addr[0] !== 8'd7) begin bad++; $display("FAIL repeat_addr: got %0d want 7", log_addr[0]); end
    end
    $display("test_repeat_ly done");
  endtask

  task automatic test_reset_in_strobe();
    do_reset();
    upd = 1'b1;
    set_line(8'd3); tick();
    set_line(8'd4); tick();
    upd = 1'b0;
    tick();
    total++;
    if (wr_en !== 1'b1) begin bad++; $display("FAIL abort_in_strobe: wr_en got %b want 1", wr_en); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (wr_en !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_clear: got wr_en=%b busy=%b want 0,0", wr_en, busy);
    end
    log_addr.delete();
    log_cyc.delete();
    log_d0.delete();
    log_d1.delete();
    upd = 1'b1;
    set_line(8'd0);
    tick();
    upd = 1'b0;
    total++;
    if (frame_start !== 1'b1) begin bad++; $display("FAIL abort_frame_start: got %b want 1", frame_start); end
    for (int i = 0; i < 8; i++) tick();
    total++;
    if (log_addr.size() != 1 || log_addr[0] !== 8'd0) begin
      bad++;
      $display("FAIL abort_recapture: got %0d writes want 1 at addr 0", log_addr.size());
    end
    $display("test_reset_in_strobe done");
  endtask

`ifdef LINE_DROP_CNT_EN
  task automatic test_drop_count();
    do_reset();
    upd = 1'b1;
    for (int i = 0; i < 600; i++) begin
      set_line((i % 2 == 0) ? 8'd1 : 8'd2);
      tick();
    end
    upd = 1'b0;
    total++;
    if (drop_count !== 8'hFF || overflow !== 1'b1) begin
      bad++;
      $display("FAIL drop_saturate: got cnt=%0d ovf=%b want 255,1", drop_count, overflow);
    end
    do_reset();
    total++;
    if (drop_count !== 8'h00 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL drop_clear: got cnt=%0d ovf=%b want 0,0", drop_count, overflow);
    end
    $display("test_drop_count done");
  endtask
`endif

  initial begin
    reset = 1'b1;
    upd   = 1'b0;
    set_line(8'd0);
    test_reset();
    test_single_line();
    test_back_to_back();
    test_vblank_frame();
    test_repeat_ly();
    test_reset_in_strobe();
`ifdef LINE_DROP_CNT_EN
    test_drop_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
